rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters.
- m0 is the CPU instruction fetch. m1 is the APB-side read path (debug/readback of code.mem contents).
- Per cycle: one grant, fixed priority to m0, with a starvation bound that forces an m1 grant. Read data is registered and returned one cycle after grant.
- Sits between the CPU core, the APB bridge and rom; rom itself is unchanged (byte address in, word indexed by addr[31:2]).

Parameters:
- ADDR_W, 32, byte address width of requester and ROM address ports.
- DATA_W, 32, ROM word width.
- MAX_WAIT, 4, max consecutive cycles m1 may be denied before a forced grant (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  fetch request; held with m0_addr until m0_gnt.
- m0_addr  input  ADDR_W  fetch byte address.
- m0_gnt  output  1  m0 owns the ROM this cycle (combinational).
- m0_rvalid  output  1  m0_rdata valid; one-cycle pulse per grant.
- m0_rdata  output  DATA_W  registered fetch data.
- m0_err  output  1  with m0_rvalid: granted address had addr[1:0]!=0.
- m1_req  input  1  readback request; held with m1_addr until m1_gnt.
- m1_addr  input  ADDR_W  readback byte address.
- m1_gnt  output  1  m1 owns the ROM this cycle (combinational).
- m1_rvalid  output  1  m1_rdata valid pulse.
- m1_rdata  output  DATA_W  registered readback data.
- m1_err  output  1  misalignment flag for m1, same rule as m0_err.
- rom_addr  output  ADDR_W  address driven to rom.
- rom_data  input  DATA_W  rom combinational read data.

Behaviour:
- Reset (async, reset=1): gnt both 0 (forced, even if req=1), rvalid both 0, rdata both 0, err both 0, wait_cnt 0, owner_q NONE, rom_addr 0.
- Grant selection, cycle N (combinational):
  - m1 wins if wait_cnt==MAX_WAIT && m1_req.
  - Else m0 wins if m0_req.
  - Else m1 wins if m1_req.
  - Never both grants; rom_addr = granted master's addr, else 0.
- Data return, edge ending cycle N: rom_data latched into the winner's rdata; winner's rvalid=1 and err=(addr[1:0]!=0) in cycle N+1. Latency is exactly 1.
- Non-winner's rdata holds its last value; its rvalid and err are 0.
- owner_q records the cycle-N winner (NONE, M0, M1). It is used only to steer the registered data.
- Back-to-back: a master may re-request in N+1 and be granted again in N+1. Full throughput: one word per cycle.
- Starvation counter wait_cnt (width clog2(MAX_WAIT+1)):
  - m1_req && !m1_gnt: increment, saturate at MAX_WAIT.
  - m1_gnt or !m1_req: clear to 0.
  - After a forced m1 grant, m0 regains priority next cycle. Under continuous contention m1 gets at most one grant per MAX_WAIT+1 cycles and is never starved longer.
- Simultaneous req with wait_cnt<MAX_WAIT: m0 wins.
- Request dropped before grant: permitted, no response. Counter clears.
- Misaligned address: still serviced (ROM drops addr[1:0]); err flagged only.
- Reset mid-operation: a pending rvalid is discarded. No output pulses in the first cycle after release unless granted in it.

Decomposition:
- Package rom_arb_pkg:
  - typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e.
  - localparam DEFAULT_MAX_WAIT = 4.
- No sub-module: the arbitration combinational block, counter and output registers fit one module. rom stays an external instance wired to rom_addr/rom_data.

Test Plan:
1. Reset: assert reset with both req=1 → both gnt=0, rvalid=0, rdata=0. Bench ROM model rom_data = ~rom_addr.
2. Single fetch: m0_req=1, m0_addr=0x0000_0010 at cycle 1 → m0_gnt=1 cycle 1; m0_rvalid=1, m0_rdata=0xFFFF_FFEF, m0_err=0 cycle 2.
3. Contention: both req continuous, MAX_WAIT=4 → m0_gnt in cycles 1-4, m1_gnt in cycle 5, pattern repeats with period 5; never both grants high.
4. Back-to-back: m1 alone, addresses 0x0, 0x4, 0x8 in cycles 1-3 → m1_rvalid cycles 2-4 with rdata 0xFFFF_FFFF, 0xFFFF_FFFB, 0xFFFF_FFF7.
5. Misaligned: m0_addr=0x0000_0006 → m0_rvalid with m0_err=1, rdata=0xFFFF_FFF9.
6. Reset mid-access: grant m0 in cycle 1, assert reset in cycle 2 before the edge → m0_rvalid stays 0, wait_cnt=0 after release.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the instruction ROM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rom_arb_pkg;

  // Which master the ROM served in the previous cycle; steers the registered read data.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/rom_arbiter.sv
// Shares one combinational instruction ROM between CPU fetch (m0) and APB readback (m1).
// Latency: grant is combinational in cycle N; rdata/rvalid/err are registered and appear in cycle N+1.
// Backpressure: a requester holds req/addr until its gnt; m0 has priority, and m1 is force-granted after MAX_WAIT denials.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   m0_req/addr/gnt    - fetch request, byte address, combinational grant
//   m0_rvalid/rdata/err- registered fetch response (err = misaligned address)
//   m1_*               - same set for the readback master
//   rom_addr/rom_data  - address to and combinational data from the external rom
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  owner_e           winner;
  owner_e           owner_q;
  logic             err_q;
  logic             misaligned;

  // Grant selection. Grants are suppressed while reset is held so that a
  // request present during reset never reaches the ROM.
  always_comb begin
    winner   = OWN_NONE;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    rom_addr = '0;
    if (!reset) begin
      if (m1_req && (wait_cnt == CNT_MAX)) begin
        winner = OWN_M1;
      end else if (m0_req) begin
        winner = OWN_M0;
      end else if (m1_req) begin
        winner = OWN_M1;
      end
    end
    case (winner)
      OWN_M0: begin
        m0_gnt   = 1'b1;
        rom_addr = m0_addr;
      end
      OWN_M1: begin
        m1_gnt   = 1'b1;
        rom_addr = m1_addr;
      end
      default: ;
    endcase
  end

  // rom ignores addr[1:0]; the access still happens, only the flag is raised.
  assign misaligned = (rom_addr[1:0] != 2'b00);

  // Starvation counter: counts consecutive cycles m1 asked and lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (m1_req && !m1_gnt) begin
      if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Response registers. Only the winner's rdata is updated; the other master's
  // rdata keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      owner_q <= winner;
      err_q   <= misaligned;
      if (winner == OWN_M0) begin
        m0_rdata <= rom_data;
      end
      if (winner == OWN_M1) begin
        m1_rdata <= rom_data;
      end
    end
  end

  assign m0_rvalid = (owner_q == OWN_M0);
  assign m1_rvalid = (owner_q == OWN_M1);
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed testbench for rom_arbiter; rom modelled as rom_data = ~rom_addr.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Summary line reports checks and errors.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = ~rom_addr;

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m0_err   (m0_err),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .m1_err   (m1_err),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  // Advance to the start of the next cycle (just after the rising edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    m0_req  = 1'b1;
    m0_addr = 32'h0000_0010;
    m1_req  = 1'b1;
    m1_addr = 32'h0000_0020;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
    end
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rvalid_err: got %b expected 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata});
    end
    checks++;
    if (rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
    end
    next_cycle();
    reset  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    m0_req  = 1'b1;
    m0_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || rom_addr !== 32'h0000_0010) begin
      errors++;
      $display("FAIL fetch_gnt: got gnt=%b addr=%h expected gnt=10 addr=00000010", {m0_gnt, m1_gnt}, rom_addr);
    end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hFFFF_FFEF || m0_err !== 1'b0 || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_data: got rv=%b d=%h err=%b m1rv=%b expected rv=1 d=ffffffef err=0 m1rv=0",
               m0_rvalid, m0_rdata, m0_err, m1_rvalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hFFFF_FFEF) begin
      errors++;
      $display("FAIL fetch_pulse: got rv=%b d=%h expected rv=0 d=ffffffef", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_contention();
    logic exp_m1;
    logic prev_m1;
    prev_m1 = 1'b0;
    m0_addr = 32'h0000_0020;
    m1_addr = 32'h0000_0040;
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      m0_req = 1'b1;
      m1_req = 1'b1;
      exp_m1 = (i % 5 == 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {~exp_m1, exp_m1}) begin
        errors++;
        $display("FAIL contention_gnt cycle %0d: got %b expected %b", i, {m0_gnt, m1_gnt}, {~exp_m1, exp_m1});
      end
      if (i >= 2) begin
        checks++;
        if ({m0_rvalid, m1_rvalid} !== {~prev_m1, prev_m1}) begin
          errors++;
          $display("FAIL contention_rvalid cycle %0d: got %b expected %b", i, {m0_rvalid, m1_rvalid}, {~prev_m1, prev_m1});
        end
      end
      prev_m1 = exp_m1;
    end
    next_cycle();
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hFFFF_FFBF || m0_rdata !== 32'hFFFF_FFDF) begin
      errors++;
      $display("FAIL contention_data: got m1rv=%b m1d=%h m0d=%h expected 1 ffffffbf ffffffdf",
               m1_rvalid, m1_rdata, m0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    exp_d[0] = 32'hFFFF_FFFF; exp_d[1] = 32'hFFFF_FFFB; exp_d[2] = 32'hFFFF_FFF7;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m1_req  = (i < 3);
      m1_addr = (i < 3) ? addrs[i] : 32'h0;
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gnt %0d: got m1_gnt=%b m0_gnt=%b expected 1 0", i, m1_gnt, m0_gnt);
        end
      end
      if (i > 0) begin
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== exp_d[i-1] || m1_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data %0d: got rv=%b d=%h err=%b expected rv=1 d=%h err=0",
                   i, m1_rvalid, m1_rdata, m1_err, exp_d[i-1]);
        end
      end
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'hFFFF_FFF7) begin
      errors++;
      $display("FAIL b2b_hold: got rv=%b d=%h expected rv=0 d=fffffff7", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_misaligned();
    next_cycle();
    m0_req  = 1'b1;
    m0_addr = 32'h0000_0006;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || rom_addr !== 32'h0000_0006) begin
      errors++;
      $display("FAIL misaligned_gnt: got gnt=%b addr=%h expected 1 00000006", m0_gnt, rom_addr);
    end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'hFFFF_FFF9 || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_data: got rv=%b err=%b d=%h m1err=%b expected 1 1 fffffff9 0",
               m0_rvalid, m0_err, m0_rdata, m1_err);
    end
    checks++;
    if (m1_rdata !== 32'hFFFF_FFF7) begin
      errors++;
      $display("FAIL misaligned_m1_hold: got %h expected fffffff7", m1_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_err !== 1'b0 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_clear: got err=%b rv=%b expected 0 0", m0_err, m0_rvalid);
    end
  endtask

  task automatic test_reset_mid_access();
    next_cycle();
    m0_req  = 1'b1;
    m0_addr = 32'h0000_0010;
    m1_req  = 1'b1;
    m1_addr = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_gnt: got %b expected 10", {m0_gnt, m1_gnt});
    end
    // Reset lands before the edge that would have captured the response.
    reset = 1'b1;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_gnt_forced: got %b expected 00", {m0_gnt, m1_gnt});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_rvalid: got rv=%b d=%h expected 0 0", m0_rvalid, m0_rdata);
    end
    next_cycle();
    reset  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || dut.wait_cnt !== 3'd0) begin
      errors++;
      $display("FAIL midreset_release: got rv=%b%b wait_cnt=%0d expected 00 0",
               m0_rvalid, m1_rvalid, dut.wait_cnt);
    end
  endtask

  initial begin
    reset   = 1'b1;
    m0_req  = 1'b0;
    m0_addr = 32'h0;
    m1_req  = 1'b0;
    m1_addr = 32'h0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
